// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

    // Width of the big-endian word-count field that prefixes every image
    localparam int LEN_W = 16;

    // Stream bytes packed into one instruction word
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } boot_state_e;

    // Running modulo-256 byte sum used by the optional image checksum
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/imem_boot_loader_word_packer.sv
// Packs a byte stream MSB-first into 32-bit words. The finished word and its
// write strobe are registered, so the strobe appears one cycle after the
// handshake of the word's last byte. byte_idx tells the caller which byte of
// the current word the next strobe will carry.
module boot_word_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [7:0]  in_byte,
    input  logic        strobe,
    output logic [31:0] word,
    output logic        word_valid,
    output logic [1:0]  byte_idx
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [23:0] asm_r;
    logic [1:0]  idx_r;
    logic [31:0] word_r;
    logic        valid_r;

    // Shift accepted bytes into the assembly register and emit each completed word
    always_ff @(posedge clk) begin
        if (!rst) begin
            asm_r   <= 24'd0;
            idx_r   <= 2'd0;
            word_r  <= 32'd0;
            valid_r <= 1'b0;
        end else if (clear) begin
            asm_r   <= 24'd0;
            idx_r   <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= strobe && (idx_r == LAST_IDX);
            if (strobe) begin
                asm_r <= {asm_r[15:0], in_byte};
                idx_r <= idx_r + 2'd1;
                if (idx_r == LAST_IDX) begin
                    word_r <= {asm_r, in_byte};
                end else begin
                    word_r <= word_r;
                end
            end else begin
                asm_r  <= asm_r;
                idx_r  <= idx_r;
                word_r <= word_r;
            end
        end
    end

    assign word       = word_r;
    assign word_valid = valid_r;
    assign byte_idx   = idx_r;

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-serial boot loader: holds the core in reset, receives a length-prefixed
// image over valid/ready, writes it into instruction memory from word 0 and
// then releases the core.
// Optional feature: define IMEM_BOOT_CHECKSUM_EN to require one trailing
// checksum byte that makes the modulo-256 sum of all data bytes zero.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);

    // Comparison width wide enough for both the length field and the word counter
    localparam int CMP_W = (ADDR_W + 1 > LEN_W + 1) ? ADDR_W + 1 : LEN_W + 1;
    localparam logic [CMP_W-1:0] CMP_ZERO  = {CMP_W{1'b0}};
    localparam logic [CMP_W-1:0] CAP_WORDS = {{(CMP_W-1){1'b0}}, 1'b1} << ADDR_W;
    localparam logic [ADDR_W:0]  CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [1:0]       LAST_IDX  = 2'(BYTES_PER_WORD - 1);

    boot_state_e state_r, next_state_s;

    logic [LEN_W-1:0]  len_r;
    logic [ADDR_W:0]   word_cnt_r;
    logic [ADDR_W-1:0] im_addr_r;
    logic              rx_ready_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic              cpu_rst_r;

    logic              xfer_s;
    logic              start_ok_s;
    logic              data_strobe_s;
    logic [CMP_W-1:0]  cnt_ext_s;
    logic [CMP_W-1:0]  len_ext_s;
    logic [CMP_W-1:0]  len_new_s;
    logic [1:0]        byte_idx_s;
    logic [31:0]       pk_word_s;
    logic              pk_valid_s;

    assign xfer_s     = rx_valid && rx_ready_r;
    assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) ||
                                  (state_r == ST_ERR));
    assign cnt_ext_s  = CMP_W'(word_cnt_r);
    assign len_ext_s  = CMP_W'(len_r);
    assign len_new_s  = CMP_W'({len_r[LEN_W-1 -: 8], rx_data});

`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0] csum_r;
    logic       csum_phase_s;

    // Once every word has been counted, the next DATA byte is the checksum
    assign csum_phase_s  = (state_r == ST_DATA) && (cnt_ext_s == len_ext_s);
    assign data_strobe_s = xfer_s && (state_r == ST_DATA) && !csum_phase_s;
`else
    logic last_byte_s;

    assign data_strobe_s = xfer_s && (state_r == ST_DATA);
    assign last_byte_s   = (byte_idx_s == LAST_IDX) &&
                           ((cnt_ext_s + {{(CMP_W-1){1'b0}}, 1'b1}) == len_ext_s);
`endif

    boot_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok_s),
        .in_byte    (rx_data),
        .strobe     (data_strobe_s),
        .word       (pk_word_s),
        .word_valid (pk_valid_s),
        .byte_idx   (byte_idx_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: length parse, data phase and terminal states
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    next_state_s = ST_LEN_HI;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_LEN_HI: begin
                if (xfer_s) begin
                    next_state_s = ST_LEN_LO;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_LEN_LO: begin
                if (xfer_s) begin
                    if (len_new_s == CMP_ZERO) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                        next_state_s = ST_DATA;
`else
                        next_state_s = ST_DONE;
`endif
                    end else if (len_new_s > CAP_WORDS) begin
                        next_state_s = ST_ERR;
                    end else begin
                        next_state_s = ST_DATA;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_DATA: begin
                if (xfer_s) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                    if (csum_phase_s) begin
                        if (csum_add(csum_r, rx_data) == 8'd0) begin
                            next_state_s = ST_DRAIN;
                        end else begin
                            next_state_s = ST_ERR;
                        end
                    end else begin
                        next_state_s = state_r;
                    end
`else
                    if (last_byte_s) begin
                        next_state_s = ST_DRAIN;
                    end else begin
                        next_state_s = state_r;
                    end
`endif
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_DRAIN: begin
                next_state_s = ST_DONE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Length latch, word counter and write address
    always_ff @(posedge clk) begin
        if (!rst) begin
            len_r      <= {LEN_W{1'b0}};
            word_cnt_r <= {(ADDR_W+1){1'b0}};
            im_addr_r  <= {ADDR_W{1'b0}};
        end else if (start_ok_s) begin
            len_r      <= {LEN_W{1'b0}};
            word_cnt_r <= {(ADDR_W+1){1'b0}};
        end else begin
            if (xfer_s && (state_r == ST_LEN_HI)) begin
                len_r[LEN_W-1 -: 8] <= rx_data;
            end
            if (xfer_s && (state_r == ST_LEN_LO)) begin
                len_r[7:0] <= rx_data;
            end
            if (data_strobe_s && (byte_idx_s == LAST_IDX)) begin
                im_addr_r  <= word_cnt_r[ADDR_W-1:0];
                word_cnt_r <= word_cnt_r + CNT_ONE;
            end
        end
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Accumulate the data-byte sum for the trailing checksum test
    always_ff @(posedge clk) begin
        if (!rst) begin
            csum_r <= 8'd0;
        end else if (start_ok_s) begin
            csum_r <= 8'd0;
        end else if (data_strobe_s) begin
            csum_r <= csum_add(csum_r, rx_data);
        end else begin
            csum_r <= csum_r;
        end
    end
`endif

    // Status outputs registered from the next state so they track the FSM exactly
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            cpu_rst_r  <= 1'b1;
        end else begin
            rx_ready_r <= (next_state_s == ST_LEN_HI) || (next_state_s == ST_LEN_LO) ||
                          (next_state_s == ST_DATA);
            busy_r     <= (next_state_s == ST_LEN_HI) || (next_state_s == ST_LEN_LO) ||
                          (next_state_s == ST_DATA)   || (next_state_s == ST_DRAIN);
            done_r     <= (next_state_s == ST_DONE);
            err_r      <= (next_state_s == ST_ERR);
            cpu_rst_r  <= (next_state_s != ST_DONE);
        end
    end

    assign rx_ready = rx_ready_r;
    assign im_we    = pk_valid_s;
    assign im_addr  = im_addr_r;
    assign im_wdata = pk_word_s;
    assign cpu_rst  = cpu_rst_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;
    assign word_cnt = word_cnt_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a write scoreboard.
// Built with a small memory (ADDR_W=4) so the capacity boundary is cheap to reach.
// Honours IMEM_BOOT_CHECKSUM_EN by appending the trailing checksum byte.
module tb_imem_boot_loader;

    localparam int AW = 4;
`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam int DONE_LAT = 11;
    localparam int REL_LAT  = 2;
`else
    // done is high in the 12th cycle counting the first handshake cycle as 1
    localparam int DONE_LAT = 10;
    localparam int REL_LAT  = 1;
`endif

    logic          clk, rst, start, rx_valid, rx_ready;
    logic [7:0]    rx_data;
    logic          im_we, cpu_rst, busy, done, err;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic [AW:0]   word_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_total = 0;
    int wr_mark = 0;
    int last_we_cyc = 0;
    int last_hs = 0;
    int first_hs = 0;
    int done_cyc = 0;

    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] mon_exp;
    logic [31:0]    img_q[$];

    imem_boot_loader #(.ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .word_cnt (word_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Write monitor: every im_we must match the oldest expected write
    initial forever begin
        @(negedge clk);
        if (im_we === 1'b1) begin
            wr_total++;
            last_we_cyc = cyc;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_write: observed addr %0h data %h, expected no write",
                       im_addr, im_wdata);
            end
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                checks++;
                assert ({im_addr, im_wdata} === mon_exp) else begin
                    errors++;
                    $error("FAIL write: observed %0h:%h expected %0h:%h",
                           im_addr, im_wdata, mon_exp[AW+31:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("rx_ready_wait", 64'(t < 50), 64'd1);
        last_hs = cyc + 1;
    endtask

    // Sends length field, img_q words and (optionally) the checksum byte.
    // abort_after > 0 returns right after that many data bytes are driven.
    task automatic send_body(input int n_field, input int nwords, input int gap_max,
                             input int abort_after, input bit send_csum,
                             input logic [7:0] csum_adj, input bit start_mid);
        logic [15:0] n16;
        logic [31:0] w;
        logic [7:0]  b;
        logic [7:0]  sum;
        int nb;
        n16 = 16'(n_field);
        sum = 8'd0;
        nb  = 0;
        send_byte(n16[15:8], int'($urandom_range(gap_max, 0)));
        first_hs = last_hs;
        send_byte(n16[7:0], int'($urandom_range(gap_max, 0)));
        for (int i = 0; i < nwords; i++) begin
            w = img_q[i];
            for (int j = 0; j < 4; j++) begin
                b = w[31 - 8*j -: 8];
                if (j == 3) exp_q.push_back({AW'(i), w});
                sum = sum + b;
                start = (start_mid && nb == 5) ? 1'b1 : 1'b0;
                send_byte(b, int'($urandom_range(gap_max, 0)));
                nb++;
                if (abort_after > 0 && nb == abort_after) return;
            end
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        if (send_csum) send_byte(8'd0 - sum + csum_adj, int'($urandom_range(gap_max, 0)));
`else
        if (send_csum) sum = sum + csum_adj;
`endif
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (done !== 1'b1 && err !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("end_wait", 64'(t < 300), 64'd1);
        done_cyc = cyc;
    endtask

    task automatic check_reset_outputs(input string w);
        chk({w, "_rx_ready"}, 64'(rx_ready), 64'd0);
        chk({w, "_im_we"},    64'(im_we),    64'd0);
        chk({w, "_im_addr"},  64'(im_addr),  64'd0);
        chk({w, "_im_wdata"}, 64'(im_wdata), 64'd0);
        chk({w, "_cpu_rst"},  64'(cpu_rst),  64'd1);
        chk({w, "_busy"},     64'(busy),     64'd0);
        chk({w, "_done"},     64'(done),     64'd0);
        chk({w, "_err"},      64'(err),      64'd0);
        chk({w, "_word_cnt"}, 64'(word_cnt), 64'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // rx_valid in IDLE is ignored
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (3) @(negedge clk);
        chk("idle_rx_ready", 64'(rx_ready), 64'd0);
        chk("idle_busy",     64'(busy),     64'd0);
        rx_valid = 1'b0;

        // Normal two-word load, continuous valid
        img_q = '{32'h12345678, 32'h9ABCDEF0};
        pulse_start();
        chk("ld_busy",     64'(busy),     64'd1);
        chk("ld_rx_ready", 64'(rx_ready), 64'd1);
        chk("ld_cpu_rst",  64'(cpu_rst),  64'd1);
        send_body(2, 2, 0, 0, 1'b1, 8'h00, 1'b0);
        wait_end();
        chk("norm_done",     64'(done),     64'd1);
        chk("norm_cpu_rst",  64'(cpu_rst),  64'd0);
        chk("norm_err",      64'(err),      64'd0);
        chk("norm_busy",     64'(busy),     64'd0);
        chk("norm_rx_ready", 64'(rx_ready), 64'd0);
        chk("norm_word_cnt", 64'(word_cnt), 64'd2);
        chk("norm_pending",  64'(exp_q.size()), 64'd0);
        chk("norm_done_lat", 64'(done_cyc - first_hs), 64'(DONE_LAT));
        chk("norm_release",  64'(done_cyc - last_we_cyc), 64'(REL_LAT));

        // Reload from DONE with gaps and a start pulse while busy
        img_q = '{32'hCAFEF00D, 32'h01020304, 32'hDEADBEEF};
        wr_mark = wr_total;
        pulse_start();
        chk("reload_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("reload_done",    64'(done),    64'd0);
        send_body(3, 3, 3, 0, 1'b1, 8'h00, 1'b1);
        wait_end();
        chk("reload_done_end", 64'(done),     64'd1);
        chk("reload_word_cnt", 64'(word_cnt), 64'd3);
        chk("reload_writes",   64'(wr_total - wr_mark), 64'd3);
        chk("reload_pending",  64'(exp_q.size()), 64'd0);

        // Zero length
        wr_mark = wr_total;
        pulse_start();
        send_body(0, 0, 0, 0, 1'b1, 8'h00, 1'b0);
        wait_end();
        chk("zero_done",     64'(done),     64'd1);
        chk("zero_cpu_rst",  64'(cpu_rst),  64'd0);
        chk("zero_word_cnt", 64'(word_cnt), 64'd0);
        chk("zero_writes",   64'(wr_total - wr_mark), 64'd0);

        // Oversize: 17 words into a 16-word memory
        wr_mark = wr_total;
        pulse_start();
        send_body(17, 0, 0, 0, 1'b0, 8'h00, 1'b0);
        wait_end();
        repeat (2) @(negedge clk);
        chk("over_err",      64'(err),      64'd1);
        chk("over_done",     64'(done),     64'd0);
        chk("over_cpu_rst",  64'(cpu_rst),  64'd1);
        chk("over_rx_ready", 64'(rx_ready), 64'd0);
        chk("over_busy",     64'(busy),     64'd0);
        chk("over_writes",   64'(wr_total - wr_mark), 64'd0);

        // Exactly full memory: 16 words
        img_q = {};
        for (int i = 0; i < 16; i++) img_q.push_back({8'(i), 8'hA5, 8'(~i), 8'h3C});
        pulse_start();
        send_body(16, 16, 0, 0, 1'b1, 8'h00, 1'b0);
        wait_end();
        chk("full_done",     64'(done),     64'd1);
        chk("full_word_cnt", 64'(word_cnt), 64'd16);
        chk("full_pending",  64'(exp_q.size()), 64'd0);

        // Gapped 3-word load aborted by reset after data byte 6
        img_q = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        pulse_start();
        send_body(3, 3, 2, 6, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rx_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        chk("abort_pending", 64'(exp_q.size()), 64'd0);
        rst = 1'b1;
        wr_mark = wr_total;
        repeat (3) @(negedge clk);
        chk("abort_no_we", 64'(wr_total - wr_mark), 64'd0);
        pulse_start();
        send_body(3, 3, 2, 0, 1'b1, 8'h00, 1'b0);
        wait_end();
        chk("after_abort_done", 64'(done),     64'd1);
        chk("after_abort_cnt",  64'(word_cnt), 64'd3);
        chk("after_abort_pend", 64'(exp_q.size()), 64'd0);

`ifdef IMEM_BOOT_CHECKSUM_EN
        // 00 01 01 02 03 04 F6 passes, same stream ending F5 fails
        img_q = '{32'h01020304};
        pulse_start();
        send_body(1, 1, 0, 0, 1'b1, 8'h00, 1'b0);
        wait_end();
        chk("csum_ok_done", 64'(done), 64'd1);
        wr_mark = wr_total;
        pulse_start();
        send_body(1, 1, 0, 0, 1'b1, 8'hFF, 1'b0);
        wait_end();
        chk("csum_bad_err",     64'(err),     64'd1);
        chk("csum_bad_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("csum_bad_writes",  64'(wr_total - wr_mark), 64'd1);
        chk("csum_bad_pending", 64'(exp_q.size()), 64'd0);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
